// File: rtl/ucsbece154b_branch_resolve.sv
// Branch resolution stage.
// Carries the fetch-time prediction (taken, target, PHT index, PC) through the
// D and E pipeline registers. In E it compares that prediction with the actual
// control-flow outcome. From the comparison it raises a combinational redirect,
// drives the predictor's BTB/PHT training ports and keeps saturating
// performance counters.
//
// Pipeline register semantics: an entry is "valid" when its valid bit is set.
// F->D: flush clears the valid bit, and flush wins over stall. A stall holds
// every D field. Otherwise the F fields are captured with valid=1.
// D->E: flush clears the valid bit. Otherwise E takes D as-is. E never stalls,
// so a held D entry is normally paired with an E flush by the hazard unit.
// A flush only affects the next E entry. The E outputs of the current cycle
// always reflect the entry sitting in E right now.
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic                               StallD_i,
  input  logic                               FlushD_i,
  input  logic                               FlushE_i,
  input  logic [31:0]                        PCF_i,
  input  logic                               BranchTakenF_i,
  input  logic [31:0]                        BTBtargetF_i,
  input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
  input  logic [6:0]                         opE_i,
  input  logic                               BranchCondE_i,
  input  logic [31:0]                        PCTargetE_i,
  input  logic [31:0]                        PCPlus4E_i,
  output logic                               MispredictE_o,
  output logic [31:0]                        PCCorrectE_o,
  output logic                               BTB_we_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
  output logic [31:0]                        BTBwritedata_o,
  output logic                               PHTwe_o,
  output logic                               PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
  output logic [31:0]                        BranchCount_o,
  output logic [31:0]                        MispredictCount_o
);

  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // D stage registers
  // ---------------------------------------------------------------------------
  logic                    valid_d_q, valid_d_d;
  logic [31:0]             pc_d_q, pc_d_d;
  logic                    taken_d_q, taken_d_d;
  logic [31:0]             tgt_d_q, tgt_d_d;
  logic [NUM_GHR_BITS-1:0] pht_d_q, pht_d_d;

  // ---------------------------------------------------------------------------
  // E stage registers
  // ---------------------------------------------------------------------------
  logic                    valid_e_q, valid_e_d;
  logic [31:0]             pc_e_q, pc_e_d;
  logic                    taken_e_q, taken_e_d;
  logic [31:0]             tgt_e_q, tgt_e_d;
  logic [NUM_GHR_BITS-1:0] pht_e_q, pht_e_d;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // ---------------------------------------------------------------------------
  // E-stage decode and resolution signals
  // ---------------------------------------------------------------------------
  logic is_branch_e;
  logic is_jump_e;
  logic is_cf_e;
  logic actual_taken_e;
  logic target_differs_e;
  logic mispredict_raw_e;

  // Only pc[I+1:2] is needed to index the BTB.
  // The remaining PC bits ride along for visibility in E.
  logic unused_pc_e_bits;
  assign unused_pc_e_bits = ^{pc_e_q[31:BTB_IDX_W+2], pc_e_q[1:0]};

  // F->D next state: flush beats stall, stall holds, otherwise capture fetch.
  always_comb begin
    valid_d_d = valid_d_q;
    pc_d_d    = pc_d_q;
    taken_d_d = taken_d_q;
    tgt_d_d   = tgt_d_q;
    pht_d_d   = pht_d_q;
    if (FlushD_i) begin
      valid_d_d = 1'b0;
    end else if (!StallD_i) begin
      valid_d_d = 1'b1;
      pc_d_d    = PCF_i;
      taken_d_d = BranchTakenF_i;
      tgt_d_d   = BTBtargetF_i;
      pht_d_d   = PHTreadaddressF_i;
    end
  end

  // F->D register with asynchronous clear of the in-flight entry.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid_d_q <= 1'b0;
      pc_d_q    <= '0;
      taken_d_q <= 1'b0;
      tgt_d_q   <= '0;
      pht_d_q   <= '0;
    end else begin
      valid_d_q <= valid_d_d;
      pc_d_q    <= pc_d_d;
      taken_d_q <= taken_d_d;
      tgt_d_q   <= tgt_d_d;
      pht_d_q   <= pht_d_d;
    end
  end

  // D->E next state: E always advances; a flush only drops validity.
  always_comb begin
    valid_e_d = valid_d_q;
    pc_e_d    = pc_d_q;
    taken_e_d = taken_d_q;
    tgt_e_d   = tgt_d_q;
    pht_e_d   = pht_d_q;
    if (FlushE_i) begin
      valid_e_d = 1'b0;
    end
  end

  // D->E register with asynchronous clear of the in-flight entry.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid_e_q <= 1'b0;
      pc_e_q    <= '0;
      taken_e_q <= 1'b0;
      tgt_e_q   <= '0;
      pht_e_q   <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      pc_e_q    <= pc_e_d;
      taken_e_q <= taken_e_d;
      tgt_e_q   <= tgt_e_d;
      pht_e_q   <= pht_e_d;
    end
  end

  // Resolve the E entry against its prediction and drive redirect/training ports.
  always_comb begin
    is_branch_e      = (opE_i == OP_BRANCH);
    is_jump_e        = (opE_i == OP_JAL) || (opE_i == OP_JALR);
    is_cf_e          = is_branch_e | is_jump_e;
    actual_taken_e   = is_jump_e | (is_branch_e & BranchCondE_i);
    target_differs_e = (tgt_e_q != PCTargetE_i);
    // A taken prediction on a non-control-flow op (BTB/PHT aliasing) resolves
    // as not taken, so it redirects to PC+4 like any other not-taken miss.
    mispredict_raw_e = (taken_e_q != actual_taken_e) |
                       (taken_e_q & actual_taken_e & target_differs_e);

    // Every output is quiet unless a valid entry occupies E.
    MispredictE_o     = 1'b0;
    PCCorrectE_o      = '0;
    BTB_we_o          = 1'b0;
    BTBwriteaddress_o = '0;
    BTBwritedata_o    = '0;
    PHTwe_o           = 1'b0;
    PHTincrement_o    = 1'b0;
    PHTwriteaddress_o = '0;
    if (valid_e_q) begin
      MispredictE_o     = mispredict_raw_e;
      PCCorrectE_o      = actual_taken_e ? PCTargetE_i : PCPlus4E_i;
      BTB_we_o          = actual_taken_e & target_differs_e;
      BTBwriteaddress_o = pc_e_q[BTB_IDX_W+1:2];
      BTBwritedata_o    = PCTargetE_i;
      PHTwe_o           = is_branch_e;
      PHTincrement_o    = is_branch_e & BranchCondE_i;
      PHTwriteaddress_o = pht_e_q;
    end
  end

  // Saturating counter increments, counted only for a valid E entry.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (valid_e_q && is_cf_e && (branch_cnt_q != CNT_MAX)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (valid_e_q && mispredict_raw_e && (mispredict_cnt_q != CNT_MAX)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign BranchCount_o     = branch_cnt_q;
  assign MispredictCount_o = mispredict_cnt_q;

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve.
// Each transaction carries its fetch-side prediction and its E-side outcome.
// It is queued when D captures it. It is popped and compared in the cycle it
// occupies E, with that cycle's opE/cond/targets taken from the queued entry.
module tb_ucsbece154b_branch_resolve;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
    logic [4:0]  pht;
    logic [6:0]  op;
    logic        cond;
    logic [31:0] ptgt;
    logic [31:0] pp4;
  } txn_t;

  typedef struct packed {
    logic        mis;
    logic [31:0] pcc;
    logic        btb_we;
    logic [4:0]  btb_addr;
    logic [31:0] btb_data;
    logic        pht_we;
    logic        pht_inc;
    logic [4:0]  pht_addr;
  } res_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_i;
  logic        StallD_i, FlushD_i, FlushE_i;
  logic [31:0] PCF_i;
  logic        BranchTakenF_i;
  logic [31:0] BTBtargetF_i;
  logic [4:0]  PHTreadaddressF_i;
  logic [6:0]  opE_i;
  logic        BranchCondE_i;
  logic [31:0] PCTargetE_i, PCPlus4E_i;
  logic        MispredictE_o;
  logic [31:0] PCCorrectE_o;
  logic        BTB_we_o;
  logic [4:0]  BTBwriteaddress_o;
  logic [31:0] BTBwritedata_o;
  logic        PHTwe_o, PHTincrement_o;
  logic [4:0]  PHTwriteaddress_o;
  logic [31:0] BranchCount_o, MispredictCount_o;

  always #5 clk = ~clk;

  ucsbece154b_branch_resolve #(
    .NUM_BTB_ENTRIES(32),
    .NUM_GHR_BITS   (5)
  ) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .StallD_i         (StallD_i),
    .FlushD_i         (FlushD_i),
    .FlushE_i         (FlushE_i),
    .PCF_i            (PCF_i),
    .BranchTakenF_i   (BranchTakenF_i),
    .BTBtargetF_i     (BTBtargetF_i),
    .PHTreadaddressF_i(PHTreadaddressF_i),
    .opE_i            (opE_i),
    .BranchCondE_i    (BranchCondE_i),
    .PCTargetE_i      (PCTargetE_i),
    .PCPlus4E_i       (PCPlus4E_i),
    .MispredictE_o    (MispredictE_o),
    .PCCorrectE_o     (PCCorrectE_o),
    .BTB_we_o         (BTB_we_o),
    .BTBwriteaddress_o(BTBwriteaddress_o),
    .BTBwritedata_o   (BTBwritedata_o),
    .PHTwe_o          (PHTwe_o),
    .PHTincrement_o   (PHTincrement_o),
    .PHTwriteaddress_o(PHTwriteaddress_o),
    .BranchCount_o    (BranchCount_o),
    .MispredictCount_o(MispredictCount_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  txn_t        exp_q[$];
  logic        d_v = 1'b0;
  logic        e_v = 1'b0;
  logic [31:0] exp_br  = '0;
  logic [31:0] exp_mis = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_cf(input logic [6:0] op);
    return (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // Reference resolution of one E entry.
  function automatic res_t model(input txn_t t);
    res_t r;
    logic br, jmp, act;
    br  = (t.op == OP_BR);
    jmp = (t.op == OP_JAL) || (t.op == OP_JALR);
    act = jmp | (br & t.cond);
    r.mis      = (t.pred != act) | (t.pred & act & (t.tgt != t.ptgt));
    r.pcc      = act ? t.ptgt : t.pp4;
    r.btb_we   = act & (t.tgt != t.ptgt);
    r.btb_addr = t.pc[6:2];
    r.btb_data = t.ptgt;
    r.pht_we   = br;
    r.pht_inc  = br & t.cond;
    r.pht_addr = t.pht;
    return r;
  endfunction

  function automatic txn_t mk(input logic [31:0] pc, input logic pred, input logic [31:0] tgt,
                              input logic [4:0] pht, input logic [6:0] op, input logic cond,
                              input logic [31:0] ptgt, input logic [31:0] pp4);
    txn_t t;
    t.pc = pc; t.pred = pred; t.tgt = tgt; t.pht = pht;
    t.op = op; t.cond = cond; t.ptgt = ptgt; t.pp4 = pp4;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    logic [31:0] pool [4];
    pool[0] = 32'h0000_0080; pool[1] = 32'h0000_0100;
    pool[2] = 32'h0000_0200; pool[3] = $urandom & 32'hFFFF_FFFC;
    t.pc   = $urandom & 32'hFFFF_FFFC;
    t.pred = 1'($urandom_range(0, 1));
    t.ptgt = pool[$urandom_range(0, 3)];
    t.tgt  = ($urandom_range(0, 1) == 1) ? t.ptgt : pool[$urandom_range(0, 3)];
    t.pht  = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 4))
      0, 1:    t.op = OP_BR;
      2:       t.op = OP_JAL;
      3:       t.op = OP_JALR;
      default: t.op = ($urandom_range(0, 1) == 1) ? OP_ALU : OP_LD;
    endcase
    t.cond = 1'($urandom_range(0, 1));
    t.pp4  = t.pc + 32'd4;
    return t;
  endfunction

  task automatic check_outputs(input res_t r);
    check("mispredict", 32'(MispredictE_o), 32'(r.mis));
    check("pc_correct", PCCorrectE_o, r.pcc);
    check("btb_we", 32'(BTB_we_o), 32'(r.btb_we));
    check("btb_addr", 32'(BTBwriteaddress_o), 32'(r.btb_addr));
    check("btb_data", BTBwritedata_o, r.btb_data);
    check("pht_we", 32'(PHTwe_o), 32'(r.pht_we));
    check("pht_inc", 32'(PHTincrement_o), 32'(r.pht_inc));
    check("pht_addr", 32'(PHTwriteaddress_o), 32'(r.pht_addr));
    check("branch_cnt", BranchCount_o, exp_br);
    check("mispred_cnt", MispredictCount_o, exp_mis);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: entered 1 time unit after a rising edge and returns at the same
  // point one cycle later. A stall without an E flush would duplicate the D
  // entry into E, so callers always pair stall with an E flush, as the hazard
  // unit does.
  // ---------------------------------------------------------------------------
  task automatic run_cycle(input txn_t t, input logic fd, input logic sd, input logic fe);
    res_t r;
    txn_t e_t;
    logic old_d;
    PCF_i             = t.pc;
    BranchTakenF_i    = t.pred;
    BTBtargetF_i      = t.tgt;
    PHTreadaddressF_i = t.pht;
    FlushD_i          = fd;
    StallD_i          = sd;
    FlushE_i          = fe;
    if (e_v) begin
      e_t           = exp_q[0];
      opE_i         = e_t.op;
      BranchCondE_i = e_t.cond;
      PCTargetE_i   = e_t.ptgt;
      PCPlus4E_i    = e_t.pp4;
      r             = model(e_t);
    end else begin
      // An empty E with control-flow-looking inputs must still stay silent.
      opE_i         = OP_BR;
      BranchCondE_i = 1'b1;
      PCTargetE_i   = $urandom;
      PCPlus4E_i    = $urandom;
      r             = '0;
    end
    #1;
    check_outputs(r);
    @(posedge clk);
    if (e_v) begin
      e_t = exp_q.pop_front();
      if (is_cf(e_t.op) && exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 32'd1;
      if (r.mis && exp_mis != 32'hFFFF_FFFF) exp_mis = exp_mis + 32'd1;
    end
    old_d = d_v;
    if (old_d && fe && (fd || !sd)) void'(exp_q.pop_front());
    e_v = fe ? 1'b0 : old_d;
    if (fd) begin
      d_v = 1'b0;
    end else if (!sd) begin
      d_v = 1'b1;
      exp_q.push_back(t);
    end
    #1;
  endtask

  task automatic do_reset_mid();
    reset_i = 1'b1;
    exp_q.delete();
    d_v     = 1'b0;
    e_v     = 1'b0;
    exp_br  = '0;
    exp_mis = '0;
    #1;
    check_outputs('0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    txn_t a, b;
    reset_i           = 1'b1;
    StallD_i          = 1'b0;
    FlushD_i          = 1'b0;
    FlushE_i          = 1'b0;
    PCF_i             = 32'h0000_1000;
    BranchTakenF_i    = 1'b1;
    BTBtargetF_i      = 32'h0000_2000;
    PHTreadaddressF_i = 5'd9;
    opE_i             = OP_JAL;
    BranchCondE_i     = 1'b1;
    PCTargetE_i       = 32'h0000_3000;
    PCPlus4E_i        = 32'h0000_1004;
    #1;
    check_outputs('0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Directed: cold taken beq, correct prediction, predicted-taken-not-taken,
    // aliased ALU op, jalr target change, cold jal.
    run_cycle(mk(32'h40, 1'b0, 32'h0,   5'd3, OP_BR,   1'b1, 32'h80,  32'h44), 1'b0, 1'b0, 1'b0);
    run_cycle(mk(32'h40, 1'b1, 32'h80,  5'd3, OP_BR,   1'b1, 32'h80,  32'h44), 1'b0, 1'b0, 1'b0);
    run_cycle(mk(32'h40, 1'b1, 32'h80,  5'd4, OP_BR,   1'b0, 32'h80,  32'h44), 1'b0, 1'b0, 1'b0);
    run_cycle(mk(32'h10, 1'b1, 32'h80,  5'd5, OP_ALU,  1'b0, 32'h99,  32'h14), 1'b0, 1'b0, 1'b0);
    run_cycle(mk(32'h20, 1'b1, 32'h100, 5'd6, OP_JALR, 1'b0, 32'h200, 32'h24), 1'b0, 1'b0, 1'b0);
    run_cycle(mk(32'h24, 1'b0, 32'h0,   5'd7, OP_JAL,  1'b0, 32'h300, 32'h28), 1'b0, 1'b0, 1'b0);

    // Stall for three cycles with E bubbled: A must reach E exactly once.
    a = mk(32'h7C, 1'b1, 32'h80, 5'd11, OP_BR, 1'b1, 32'h80, 32'h80);
    b = rand_txn();
    run_cycle(a, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(b, 1'b0, 1'b1, 1'b1);
    run_cycle(b, 1'b0, 1'b0, 1'b0);

    // Flush and stall together: the fetched entry is dropped.
    run_cycle(mk(32'h90, 1'b0, 32'h0, 5'd12, OP_BR, 1'b1, 32'hA0, 32'h94), 1'b1, 1'b1, 1'b0);
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);

    // E flush: the current E entry still resolves, the next one is dropped.
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b1);
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);
    run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);

    // Reset with entries in flight and nonzero counters.
    do_reset_mid();

    // Random mix with occasional flushes and stall bubbles.
    for (int i = 0; i < 60; i++) begin
      logic fd, sd, fe;
      fd = ($urandom_range(0, 9) == 0);
      sd = ($urandom_range(0, 7) == 0);
      fe = sd | ($urandom_range(0, 9) == 0);
      run_cycle(rand_txn(), fd, sd, fe);
    end
    for (int i = 0; i < 3; i++) run_cycle(rand_txn(), 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
